// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86 instruction codes, register ids and write-back
//               sequencer state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] REG_NONE = 4'hF;

    // IDLE: nothing on rf_*; WR1: first write of an op visible; WR2: second
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR1  = 2'd1,
        WR2  = 2'd2
    } wb_state_t;

    // One-hot register bit used for pending-destination tracking
    function automatic logic [15:0] reg_bit(input logic [3:0] r);
        reg_bit = 16'h0001 << r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_decode.sv
`default_nettype none
// ============================================================================
// Module      : wb_decode
// Description : Maps a write-back op to zero, one or two register writes,
//               compacted so the first valid write is always in slot 0.
// Revision    : 1.0  initial release
// ============================================================================
module wb_decode
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic        Cnd,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic [1:0]  n_writes,
    output logic [3:0]  addr0,
    output logic [63:0] data0,
    output logic [3:0]  addr1,
    output logic [63:0] data1,
    output logic [15:0] dest_mask
);

    logic [3:0]  w_d0_addr;
    logic [63:0] w_d0_data;
    logic [3:0]  w_d1_addr;
    logic [63:0] w_d1_data;

    // Raw destinations per icode, then drop writes aimed at REG_NONE
    always_comb begin
        w_d0_addr = REG_NONE;
        w_d0_data = valE;
        w_d1_addr = REG_NONE;
        w_d1_data = valM;
        case (icode)
            I_RRMOVQ: if (Cnd) w_d0_addr = rB;
            I_IRMOVQ,
            I_OPQ:    w_d0_addr = rB;
            I_MRMOVQ: begin
                w_d0_addr = rA;
                w_d0_data = valM;
            end
            I_CALL,
            I_RET,
            I_PUSHQ:  w_d0_addr = REG_RSP;
            // rsp update first so popq %rsp ends with the loaded value
            I_POPQ: begin
                w_d0_addr = REG_RSP;
                w_d1_addr = rA;
            end
            I_HALT, I_NOP, I_RMMOVQ, I_JXX: ;
            default: ;
        endcase

        n_writes  = 2'd0;
        addr0     = REG_NONE;
        data0     = 64'd0;
        addr1     = REG_NONE;
        data1     = 64'd0;
        dest_mask = 16'd0;
        if (w_d0_addr != REG_NONE) begin
            n_writes  = 2'd1;
            addr0     = w_d0_addr;
            data0     = w_d0_data;
            dest_mask = reg_bit(w_d0_addr);
            if (w_d1_addr != REG_NONE) begin
                n_writes  = 2'd2;
                addr1     = w_d1_addr;
                data1     = w_d1_data;
                dest_mask = dest_mask | reg_bit(w_d1_addr);
            end
        end else if (w_d1_addr != REG_NONE) begin
            n_writes  = 2'd1;
            addr0     = w_d1_addr;
            data0     = w_d1_data;
            dest_mask = reg_bit(w_d1_addr);
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_sequencer
// Description : Schedules decoded write-back ops onto the single register
//               file write port, shares it with a debug requester under an
//               anti-starvation bound, and tracks pending destinations.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_wb_sequencer
    import y86_pkg::*;
#(
    parameter int unsigned DBG_MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [3:0]  icode,
    input  logic        Cnd,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        dbg_req,
    input  logic [3:0]  dbg_addr,
    input  logic [63:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic        busy,
    output logic [15:0] pending_mask
);

    localparam logic [7:0] C_MAX_WAIT = 8'(DBG_MAX_WAIT);

    wb_state_t   r_state;
    wb_state_t   w_state_nxt;
    logic        r_second;
    logic [3:0]  r_addr1;
    logic [63:0] r_data1;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_pending;

    logic        w_force;
    logic        w_last_visible;
    logic        w_accept;
    logic        w_issue_first;
    logic        w_issue_second;
    logic [15:0] w_clr;
    logic [15:0] w_set;

    logic [1:0]  w_n_writes;
    logic [3:0]  w_addr0;
    logic [63:0] w_data0;
    logic [3:0]  w_addr1;
    logic [63:0] w_data1;
    logic [15:0] w_dest_mask;

    wb_decode u_decode (
        .icode     (icode),
        .Cnd       (Cnd),
        .rA        (rA),
        .rB        (rB),
        .valE      (valE),
        .valM      (valM),
        .n_writes  (w_n_writes),
        .addr0     (w_addr0),
        .data0     (w_data0),
        .addr1     (w_addr1),
        .data1     (w_data1),
        .dest_mask (w_dest_mask)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: a pending second write always wins over a new accept
    always_comb begin
        w_state_nxt = IDLE;
        if (r_state == WR1 && r_second)
            w_state_nxt = WR2;
        else if (w_issue_first)
            w_state_nxt = WR1;
    end

    // Handshake, write-port arbitration and debug grant
    always_comb begin
        w_last_visible = (r_state == WR1 && !r_second) || (r_state == WR2);
        w_force        = (r_wait_cnt >= C_MAX_WAIT);
        wb_ready       = !rst && !w_force && (r_state == IDLE || w_last_visible);
        w_accept       = wb_valid && wb_ready;
        w_issue_first  = w_accept && (w_n_writes != 2'd0);
        w_issue_second = (r_state == WR1) && r_second;
        dbg_gnt        = !rst && dbg_req && !w_issue_first && !w_issue_second;
    end

    // Pending-mask update terms; popq to rsp keeps bit 4 until the second write
    always_comb begin
        w_clr = 16'd0;
        if (r_state == WR1) begin
            if (!(r_second && r_addr1 == rf_waddr))
                w_clr = reg_bit(rf_waddr);
        end else if (r_state == WR2) begin
            w_clr = reg_bit(rf_waddr);
        end
        w_set = w_accept ? w_dest_mask : 16'd0;
    end

    // Write port, second-write holding register, pending mask and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= 4'd0;
            rf_wdata   <= 64'd0;
            r_second   <= 1'b0;
            r_addr1    <= 4'd0;
            r_data1    <= 64'd0;
            r_pending  <= 16'd0;
            r_wait_cnt <= 8'd0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;

            if (!dbg_req || dbg_gnt)
                r_wait_cnt <= 8'd0;
            else if (r_wait_cnt != 8'hFF)
                r_wait_cnt <= r_wait_cnt + 8'd1;

            if (w_issue_second) begin
                rf_we    <= 1'b1;
                rf_waddr <= r_addr1;
                rf_wdata <= r_data1;
                r_second <= 1'b0;
            end else if (w_issue_first) begin
                rf_we    <= 1'b1;
                rf_waddr <= w_addr0;
                rf_wdata <= w_data0;
                r_second <= (w_n_writes == 2'd2);
                r_addr1  <= w_addr1;
                r_data1  <= w_data1;
            end else if (dbg_gnt) begin
                rf_we    <= 1'b1;
                rf_waddr <= dbg_addr;
                rf_wdata <= dbg_wdata;
            end else begin
                rf_we    <= 1'b0;
            end
        end
    end

    assign pending_mask = r_pending;
    assign busy         = |r_pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_sequencer
// Description : Directed, table-driven bench for regfile_wb_sequencer plus
//               hand-written multi-cycle sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_wb_sequencer;
    import y86_pkg::*;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  icode;
    logic        Cnd;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        dbg_req;
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_wdata;
    logic        dbg_gnt;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        busy;
    logic [15:0] pending_mask;

    int checks   = 0;
    int failures = 0;

    regfile_wb_sequencer #(.DBG_MAX_WAIT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .icode        (icode),
        .Cnd          (Cnd),
        .rA           (rA),
        .rB           (rB),
        .valE         (valE),
        .valM         (valM),
        .dbg_req      (dbg_req),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_gnt      (dbg_gnt),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .busy         (busy),
        .pending_mask (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic        cnd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] vale;
        logic [63:0] valm;
        logic        we1;
        logic [3:0]  a1;
        logic [63:0] d1;
        logic        rdy1;
        logic [15:0] m1;
        logic        we2;
        logic [3:0]  a2;
        logic [63:0] d2;
        logic [15:0] m2;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic [3:0] ic, input logic c, input logic [3:0] ra, input logic [3:0] rb,
        input logic [63:0] ve, input logic [63:0] vm,
        input logic we1, input logic [3:0] a1, input logic [63:0] d1, input logic rdy1,
        input logic [15:0] m1,
        input logic we2, input logic [3:0] a2, input logic [63:0] d2, input logic [15:0] m2);
        vec_t v;
        v.icode = ic; v.cnd = c; v.ra = ra; v.rb = rb; v.vale = ve; v.valm = vm;
        v.we1 = we1; v.a1 = a1; v.d1 = d1; v.rdy1 = rdy1; v.m1 = m1;
        v.we2 = we2; v.a2 = a2; v.d2 = d2; v.m2 = m2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                            input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm);
        wb_valid = 1'b1;
        icode = ic; Cnd = c; rA = ra; rB = rb; valE = ve; valM = vm;
    endtask

    // Advance to the next cycle: inputs change 1 time unit after posedge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Move to the sampling point (negedge) of the current cycle
    task automatic sample();
        #4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  denied;
        bit  seen_gnt;

        rst = 1'b1; wb_valid = 1'b0; icode = 4'h0; Cnd = 1'b0; rA = 4'hF; rB = 4'hF;
        valE = 64'd0; valM = 64'd0; dbg_req = 1'b0; dbg_addr = 4'd0; dbg_wdata = 64'd0;

        vecs[0]  = mk(I_IRMOVQ, 0, 4'hF, 4'h3, 64'h1234, 64'h0,   1, 4'h3, 64'h1234, 1, 16'h0008, 0, 4'h0, 64'h0,  16'h0000);
        vecs[1]  = mk(I_POPQ,   0, 4'h0, 4'hF, 64'h108,  64'hAA,  1, 4'h4, 64'h108,  0, 16'h0011, 1, 4'h0, 64'hAA, 16'h0001);
        vecs[2]  = mk(I_POPQ,   0, 4'h4, 4'hF, 64'h200,  64'hBB,  1, 4'h4, 64'h200,  0, 16'h0010, 1, 4'h4, 64'hBB, 16'h0010);
        vecs[3]  = mk(I_RRMOVQ, 0, 4'h2, 4'h1, 64'h11,   64'h0,   0, 4'h0, 64'h0,    1, 16'h0000, 0, 4'h0, 64'h0,  16'h0000);
        vecs[4]  = mk(I_RRMOVQ, 1, 4'h2, 4'h5, 64'h55,   64'h0,   1, 4'h5, 64'h55,   1, 16'h0020, 0, 4'h0, 64'h0,  16'h0000);
        vecs[5]  = mk(I_MRMOVQ, 0, 4'hF, 4'h3, 64'h99,   64'h66,  0, 4'h0, 64'h0,    1, 16'h0000, 0, 4'h0, 64'h0,  16'h0000);
        vecs[6]  = mk(I_MRMOVQ, 0, 4'h6, 4'h3, 64'h99,   64'h66,  1, 4'h6, 64'h66,   1, 16'h0040, 0, 4'h0, 64'h0,  16'h0000);
        vecs[7]  = mk(I_OPQ,    0, 4'h1, 4'hF, 64'h77,   64'h0,   0, 4'h0, 64'h0,    1, 16'h0000, 0, 4'h0, 64'h0,  16'h0000);
        vecs[8]  = mk(I_OPQ,    0, 4'h1, 4'h2, 64'h77,   64'h0,   1, 4'h2, 64'h77,   1, 16'h0004, 0, 4'h0, 64'h0,  16'h0000);
        vecs[9]  = mk(I_CALL,   0, 4'hF, 4'hF, 64'h3F8,  64'h0,   1, 4'h4, 64'h3F8,  1, 16'h0010, 0, 4'h0, 64'h0,  16'h0000);
        vecs[10] = mk(I_RET,    0, 4'hF, 4'hF, 64'h400,  64'h1000,1, 4'h4, 64'h400,  1, 16'h0010, 0, 4'h0, 64'h0,  16'h0000);
        vecs[11] = mk(I_PUSHQ,  0, 4'h3, 4'hF, 64'h3F0,  64'h0,   1, 4'h4, 64'h3F0,  1, 16'h0010, 0, 4'h0, 64'h0,  16'h0000);
        vecs[12] = mk(I_POPQ,   0, 4'hF, 4'hF, 64'h300,  64'h5,   1, 4'h4, 64'h300,  1, 16'h0010, 0, 4'h0, 64'h0,  16'h0000);
        vecs[13] = mk(I_RMMOVQ, 0, 4'h1, 4'h2, 64'h10,   64'h0,   0, 4'h0, 64'h0,    1, 16'h0000, 0, 4'h0, 64'h0,  16'h0000);
        vecs[14] = mk(I_JXX,    1, 4'h1, 4'h2, 64'h10,   64'h0,   0, 4'h0, 64'h0,    1, 16'h0000, 0, 4'h0, 64'h0,  16'h0000);
        vecs[15] = mk(I_HALT,   0, 4'h1, 4'h2, 64'h10,   64'h0,   0, 4'h0, 64'h0,    1, 16'h0000, 0, 4'h0, 64'h0,  16'h0000);
        vecs[16] = mk(I_NOP,    0, 4'h1, 4'h2, 64'h10,   64'h0,   0, 4'h0, 64'h0,    1, 16'h0000, 0, 4'h0, 64'h0,  16'h0000);
        vecs[17] = mk(4'hC,     1, 4'h1, 4'h2, 64'h10,   64'h20,  0, 4'h0, 64'h0,    1, 16'h0000, 0, 4'h0, 64'h0,  16'h0000);
        vecs[18] = mk(I_IRMOVQ, 0, 4'hF, 4'hE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                                                                  1, 4'hE, 64'hFFFF_FFFF_FFFF_FFFF, 1, 16'h4000, 0, 4'h0, 64'h0, 16'h0000);

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #5;
        chk("rst_wb_ready",  wb_ready,     0);
        chk("rst_rf_we",     rf_we,        0);
        chk("rst_pending",   pending_mask, 0);
        chk("rst_busy",      busy,         0);
        chk("rst_dbg_gnt",   dbg_gnt,      0);
        next_cycle(); rst = 1'b0;
        sample();
        chk("post_rst_ready", wb_ready, 1);
        chk("post_rst_waddr", rf_waddr, 0);
        chk("post_rst_wdata", rf_wdata, 0);

        // ---------------- table-driven single ops ----------------
        for (int i = 0; i < NV; i++) begin
            next_cycle();
            drive_op(vecs[i].icode, vecs[i].cnd, vecs[i].ra, vecs[i].rb, vecs[i].vale, vecs[i].valm);
            sample();
            chk($sformatf("v%0d_accept_ready", i), wb_ready, 1);
            next_cycle();
            wb_valid = 1'b0;
            sample();
            chk($sformatf("v%0d_we1", i), rf_we, vecs[i].we1);
            if (vecs[i].we1) begin
                chk($sformatf("v%0d_addr1", i), rf_waddr, vecs[i].a1);
                chk($sformatf("v%0d_data1", i), rf_wdata, vecs[i].d1);
            end
            chk($sformatf("v%0d_ready1", i), wb_ready, vecs[i].rdy1);
            chk($sformatf("v%0d_mask1", i), pending_mask, vecs[i].m1);
            chk($sformatf("v%0d_busy1", i), busy, |vecs[i].m1);
            next_cycle();
            sample();
            chk($sformatf("v%0d_we2", i), rf_we, vecs[i].we2);
            if (vecs[i].we2) begin
                chk($sformatf("v%0d_addr2", i), rf_waddr, vecs[i].a2);
                chk($sformatf("v%0d_data2", i), rf_wdata, vecs[i].d2);
            end
            chk($sformatf("v%0d_ready2", i), wb_ready, 1);
            chk($sformatf("v%0d_mask2", i), pending_mask, vecs[i].m2);
        end

        // ---------------- back-to-back zero-write ops ----------------
        next_cycle();
        drive_op(I_RRMOVQ, 0, 4'h2, 4'h1, 64'h11, 64'h0);
        sample();
        chk("b2b0_ready_a", wb_ready, 1);
        next_cycle();
        drive_op(I_MRMOVQ, 0, 4'hF, 4'h3, 64'h0, 64'h22);
        sample();
        chk("b2b0_ready_b", wb_ready, 1);
        chk("b2b0_we_a",    rf_we,    0);
        chk("b2b0_mask_a",  pending_mask, 0);
        next_cycle();
        wb_valid = 1'b0;
        sample();
        chk("b2b0_we_b",   rf_we,        0);
        chk("b2b0_mask_b", pending_mask, 0);

        // ---------------- same destination back-to-back: set wins ----------------
        next_cycle();
        drive_op(I_IRMOVQ, 0, 4'hF, 4'h3, 64'h1, 64'h0);
        next_cycle();
        drive_op(I_IRMOVQ, 0, 4'hF, 4'h3, 64'h2, 64'h0);
        sample();
        chk("ovl_ready", wb_ready, 1);
        chk("ovl_data1", rf_wdata, 64'h1);
        chk("ovl_mask1", pending_mask, 16'h0008);
        next_cycle();
        wb_valid = 1'b0;
        sample();
        chk("ovl_we2",   rf_we, 1);
        chk("ovl_data2", rf_wdata, 64'h2);
        chk("ovl_mask2", pending_mask, 16'h0008);
        next_cycle();
        sample();
        chk("ovl_we3",   rf_we, 0);
        chk("ovl_mask3", pending_mask, 16'h0000);

        // ---------------- popq then held op: accept from WR2 ----------------
        next_cycle();
        drive_op(I_POPQ, 0, 4'h1, 4'hF, 64'h500, 64'hCC);
        next_cycle();
        drive_op(I_IRMOVQ, 0, 4'hF, 4'h2, 64'h42, 64'h0);
        sample();
        chk("pq_hold_ready", wb_ready, 0);
        next_cycle();
        sample();
        chk("pq_wr2_ready", wb_ready, 1);
        chk("pq_wr2_addr",  rf_waddr, 4'h1);
        chk("pq_wr2_data",  rf_wdata, 64'hCC);
        chk("pq_wr2_mask",  pending_mask, 16'h0002);
        next_cycle();
        wb_valid = 1'b0;
        sample();
        chk("pq_next_addr", rf_waddr, 4'h2);
        chk("pq_next_data", rf_wdata, 64'h42);
        chk("pq_next_mask", pending_mask, 16'h0004);
        next_cycle();

        // ---------------- debug starvation bound ----------------
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            drive_op(I_IRMOVQ, 0, 4'hF, 4'h1, 64'(c), 64'h0);
        end
        next_cycle();
        drive_op(I_IRMOVQ, 0, 4'hF, 4'h1, 64'h100, 64'h0);
        dbg_req = 1'b1; dbg_addr = 4'h7; dbg_wdata = 64'hDEAD;
        denied = 0;
        seen_gnt = 1'b0;
        for (int c = 0; c < 20 && !seen_gnt; c++) begin
            sample();
            if (dbg_gnt) begin
                seen_gnt = 1'b1;
                chk("dbg_force_ready", wb_ready, 0);
            end else begin
                if (wb_ready) denied++;
                next_cycle();
                drive_op(I_IRMOVQ, 0, 4'hF, 4'h1, 64'h101 + 64'(c), 64'h0);
            end
        end
        chk("dbg_gnt_seen", seen_gnt, 1);
        chk("dbg_denied",   denied,   8);
        next_cycle();
        dbg_req = 1'b0;
        drive_op(I_IRMOVQ, 0, 4'hF, 4'h2, 64'h42, 64'h0);
        sample();
        chk("dbg_we",      rf_we,    1);
        chk("dbg_addr",    rf_waddr, 4'h7);
        chk("dbg_data",    rf_wdata, 64'hDEAD);
        chk("dbg_resume",  wb_ready, 1);
        chk("dbg_gnt_off", dbg_gnt,  0);
        next_cycle();
        wb_valid = 1'b0;
        sample();
        chk("dbg_after_addr", rf_waddr, 4'h2);
        chk("dbg_after_data", rf_wdata, 64'h42);

        // ---------------- debug on idle port ----------------
        next_cycle();
        dbg_req = 1'b1; dbg_addr = 4'h9; dbg_wdata = 64'h77;
        sample();
        chk("idle_dbg_gnt",   dbg_gnt,  1);
        chk("idle_dbg_ready", wb_ready, 1);
        next_cycle();
        dbg_req = 1'b0;
        sample();
        chk("idle_dbg_we",   rf_we,        1);
        chk("idle_dbg_addr", rf_waddr,     4'h9);
        chk("idle_dbg_data", rf_wdata,     64'h77);
        chk("idle_dbg_mask", pending_mask, 0);
        chk("idle_dbg_gnt0", dbg_gnt,      0);

        // ---------------- reset during popq ----------------
        next_cycle();
        drive_op(I_POPQ, 0, 4'h0, 4'hF, 64'h108, 64'hAA);
        next_cycle();
        wb_valid = 1'b0;
        rst = 1'b1;
        sample();
        chk("rstpq_ready_in_rst", wb_ready, 0);
        next_cycle();
        rst = 1'b0;
        sample();
        chk("rstpq_we",    rf_we,        0);
        chk("rstpq_addr",  rf_waddr,     0);
        chk("rstpq_data",  rf_wdata,     0);
        chk("rstpq_mask",  pending_mask, 0);
        chk("rstpq_busy",  busy,         0);
        chk("rstpq_gnt",   dbg_gnt,      0);
        chk("rstpq_ready", wb_ready,     1);
        next_cycle();
        sample();
        chk("rstpq_no_2nd", rf_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
